// File: rtl/sha3_block_feeder_if.sv
// Message, block, digest and output-beat channels between the SHA3 block feeder
// and its environment. "master" is the feeder's view and "slave" is the environment's view.
interface sha3_block_feeder_if #(
  parameter int RATE_WORDS   = 17,
  parameter int DIGEST_WORDS = 4
);
  logic                       s_valid;
  logic                       s_ready;
  logic [63:0]                s_data;
  logic                       s_last;
  logic [3:0]                 s_keep;
  logic                       blk_valid;
  logic                       blk_ready;
  logic [64*RATE_WORDS-1:0]   blk_data;
  logic                       blk_done;
  logic                       dig_valid;
  logic                       dig_ready;
  logic [64*DIGEST_WORDS-1:0] dig_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [63:0]                m_data;
  logic                       m_last;
  logic                       busy;

  modport master (
    input  s_valid, s_data, s_last, s_keep, blk_ready, dig_valid, dig_data, m_ready,
    output s_ready, blk_valid, blk_data, blk_done, dig_ready, m_valid, m_data, m_last, busy
  );
  modport slave (
    output s_valid, s_data, s_last, s_keep, blk_ready, dig_valid, dig_data, m_ready,
    input  s_ready, blk_valid, blk_data, blk_done, dig_ready, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/sha3_block_feeder.sv
// Packs a 64-bit little-endian message stream into padded SHA3-256 rate blocks.
// It hands the blocks to the permutation wrapper and returns the digest as four 64-bit beats.
module sha3_block_feeder #(
  parameter int         RATE_WORDS   = 17,
  parameter int         DIGEST_WORDS = 4,
  parameter logic [7:0] DOMAIN_PAD   = 8'h06
) (
  input logic                  clk,
  input logic                  rst_n,
  sha3_block_feeder_if.master  bus
);
  localparam int IW = $clog2(RATE_WORDS);
  localparam int BW = $clog2(DIGEST_WORDS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(RATE_WORDS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {FILL, SEND, PAD_FILL, SEND_PAD, WAIT_DIG, EMIT} state_e;

  state_e                         state_q;
  logic [IW-1:0]                  idx_q;
  logic [BW-1:0]                  beat_q;
  logic [RATE_WORDS-1:0][63:0]    buf_q, fill_d;
  logic [DIGEST_WORDS-1:0][63:0]  dig_q;
  logic                           done_q, pad_pend_q;
  logic                           s_ready_q, blk_valid_q, dig_ready_q, m_valid_q, m_last_q, busy_q;
  logic [63:0]                    m_data_q;

  logic        accept, keep_full, no_room;
  logic [63:0] lane_d;

  assign accept    = bus.s_valid && s_ready_q;
  assign keep_full = !bus.s_last || (bus.s_keep >= 4'd8);
  assign no_room   = keep_full && (idx_q == LAST_IDX);

  // Short final word: drop bytes past s_keep and put the domain pad byte at s_keep.
  always_comb begin
    lane_d = bus.s_data;
    if (!keep_full) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) > bus.s_keep)       lane_d[8*j +: 8] = 8'h00;
        else if (4'(j) == bus.s_keep) lane_d[8*j +: 8] = DOMAIN_PAD;
      end
    end
  end

  // The closing 0x80 is ORed, so a pad byte in lane 16 byte 7 becomes 0x86.
  always_comb begin
    fill_d         = buf_q;
    fill_d[idx_q]  = lane_d;
    if (bus.s_last) begin
      if (keep_full && !no_room) fill_d[idx_q + 1'b1][7:0] = DOMAIN_PAD;
      if (!no_room)              fill_d[RATE_WORDS-1][63]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      dig_q       <= '0;
      done_q      <= 1'b0;
      pad_pend_q  <= 1'b0;
      s_ready_q   <= 1'b1;
      blk_valid_q <= 1'b0;
      dig_ready_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: if (accept) begin
          buf_q  <= fill_d;
          busy_q <= 1'b1;
          if (bus.s_last || idx_q == LAST_IDX) begin
            state_q     <= SEND;
            s_ready_q   <= 1'b0;
            blk_valid_q <= 1'b1;
            done_q      <= bus.s_last && !no_room;
            pad_pend_q  <= bus.s_last && no_room;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SEND, SEND_PAD: if (bus.blk_ready) begin
          buf_q       <= '0;
          idx_q       <= '0;
          done_q      <= 1'b0;
          pad_pend_q  <= 1'b0;
          blk_valid_q <= 1'b0;
          if (pad_pend_q) begin
            state_q <= PAD_FILL;
          end else if (done_q) begin
            state_q     <= WAIT_DIG;
            dig_ready_q <= 1'b1;
          end else begin
            state_q   <= FILL;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        PAD_FILL: begin
          buf_q[0]            <= 64'(DOMAIN_PAD);
          buf_q[RATE_WORDS-1] <= 64'h8000_0000_0000_0000;
          done_q              <= 1'b1;
          blk_valid_q         <= 1'b1;
          state_q             <= SEND_PAD;
        end
        WAIT_DIG: if (bus.dig_valid) begin
          dig_q       <= bus.dig_data;
          beat_q      <= '0;
          dig_ready_q <= 1'b0;
          m_valid_q   <= 1'b1;
          m_data_q    <= bus.dig_data[63:0];
          m_last_q    <= (DIGEST_WORDS == 1);
          state_q     <= EMIT;
        end
        EMIT: if (bus.m_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= FILL;
          end else begin
            beat_q   <= beat_q + 1'b1;
            m_data_q <= dig_q[beat_q + 1'b1];
            m_last_q <= (beat_q + 1'b1 == LAST_BEAT);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = buf_q;
  assign bus.blk_done  = done_q;
  assign bus.dig_ready = dig_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sha3_block_feeder.sv
// Randomised scoreboard bench for sha3_block_feeder: messages are padded by a byte-level model,
// and a wrapper stand-in plus an output monitor check blocks and digest beats independently.
module tb_sha3_block_feeder;
  localparam int RW = 17;
  localparam int DW = 4;
  localparam int BLK_BYTES = 136;

  typedef struct { logic [RW*64-1:0] d; logic done; } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_block_feeder_if #(.RATE_WORDS(RW), .DIGEST_WORDS(DW)) bus();
  sha3_block_feeder #(.RATE_WORDS(RW), .DIGEST_WORDS(DW), .DOMAIN_PAD(8'h06)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  blk_t            exp_blk[$];
  logic [DW*64-1:0] dig_src[$];
  logic [64:0]     exp_beat[$];
  logic [7:0]      msg[$];
  int checks = 0;
  int errors = 0;
  int blk_count = 0;
  bit hold_blk = 0, hold_m = 0, stall5 = 0, toggle_m = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int first_diff(input logic [RW*64-1:0] a, input logic [RW*64-1:0] b);
    int r = -1;
    for (int k = RW-1; k >= 0; k--) if (a[64*k +: 64] !== b[64*k +: 64]) r = k;
    return r;
  endfunction

  function automatic logic [DW*64-1:0] rand_dig();
    logic [DW*64-1:0] d;
    for (int k = 0; k < DW*2; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic make_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  // pad10*1 with the SHA3 domain byte over the whole byte string, then cut into 136-byte blocks
  task automatic model_msg(input logic [DW*64-1:0] dig);
    logic [7:0] p[$];
    blk_t b;
    int nb;
    p = msg;
    p.push_back(8'h06);
    while (p.size() % BLK_BYTES != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nb = p.size() / BLK_BYTES;
    for (int i = 0; i < nb; i++) begin
      b.d = '0;
      for (int j = 0; j < BLK_BYTES; j++) b.d[8*j +: 8] = p[i*BLK_BYTES + j];
      b.done = (i == nb - 1);
      exp_blk.push_back(b);
    end
    dig_src.push_back(dig);
    for (int k = 0; k < DW; k++) exp_beat.push_back({k == DW-1, dig[64*k +: 64]});
  endtask

  task automatic drive_word(input logic [63:0] d, input logic l, input logic [3:0] k);
    int n = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l; bus.s_keep = k;
    while (bus.s_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout got 0 expected 1");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // tail: 0 random, 1 last word full, 2 extra empty last word (used only when len%8==0)
  task automatic send_msg(input bit push, input logic [DW*64-1:0] dig, input int tail);
    int len, nw, kept;
    bit empty_tail, last;
    logic [63:0] w;
    len = msg.size();
    if (push) model_msg(dig);
    empty_tail = (len % 8 == 0) && (len == 0 || tail == 2 || (tail == 0 && $urandom_range(0, 1) == 1));
    nw = (len + 7) / 8 + (empty_tail ? 1 : 0);
    for (int i = 0; i < nw; i++) begin
      last = (i == nw - 1);
      w = {$urandom, $urandom};
      kept = 0;
      for (int j = 0; j < 8; j++) if (i*8 + j < len) begin w[8*j +: 8] = msg[i*8 + j]; kept++; end
      drive_word(w, last, last ? 4'(kept) : 4'($urandom_range(0, 15)));
      if (last) chk("blk_latency", 64'(bus.blk_valid), 64'd1);
      else if ($urandom_range(0, 3) == 0) begin bus.s_data = {$urandom, $urandom}; @(negedge clk); end
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_blk.size() != 0 || exp_beat.size() != 0 || bus.busy !== 1'b0) && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL drain_%s got timeout expected idle", nm); end
  endtask

  task automatic check_reset(input string nm);
    chk({"rst_flags_", nm}, 64'({bus.s_ready, bus.blk_valid, bus.blk_done, bus.dig_ready,
                                bus.m_valid, bus.m_last, bus.busy}), 64'b1000000);
    chk({"rst_m_data_", nm}, bus.m_data, 64'd0);
    chk({"rst_blk_data_", nm}, 64'(first_diff(bus.blk_data, '0) + 1), 64'd0);
  endtask

  // wrapper stand-in: accepts blocks against the scoreboard, then returns a digest
  initial begin : wrapper
    bit stalled;
    int wait_n, n, bad;
    logic [RW*64-1:0] held;
    blk_t e;
    logic [DW*64-1:0] dg;
    bus.blk_ready = 1'b0; bus.dig_valid = 1'b0; bus.dig_data = '0;
    stalled = 0; wait_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin stalled = 0; wait_n = 0; bus.blk_ready = 1'b0; bus.dig_valid = 1'b0; continue; end
      if (bus.blk_valid === 1'b1) begin
        if (stalled) begin
          bad = first_diff(bus.blk_data, held);
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL blk_hold lane %0d got %h expected %h", bad, bus.blk_data[64*bad +: 64], held[64*bad +: 64]);
          end
        end
        bus.blk_ready = hold_blk ? 1'b0 : stall5 ? (wait_n >= 5) : ($urandom_range(0, 2) != 0);
        wait_n++;
        if (bus.blk_ready) begin
          blk_count++; stalled = 0; wait_n = 0;
          checks++;
          if (exp_blk.size() == 0) begin
            errors++; $display("FAIL blk_unexpected got block expected none");
          end else begin
            e = exp_blk.pop_front();
            bad = first_diff(bus.blk_data, e.d);
            if (bad >= 0 || bus.blk_done !== e.done) begin
              errors++;
              if (bad < 0) bad = 0;
              $display("FAIL blk lane %0d got %h/done %b expected %h/done %b", bad,
                       bus.blk_data[64*bad +: 64], bus.blk_done, e.d[64*bad +: 64], e.done);
            end
          end
          if (bus.blk_done === 1'b1) begin
            @(negedge clk);
            bus.blk_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dg = (dig_src.size() != 0) ? dig_src.pop_front() : '0;
            bus.dig_valid = 1'b1; bus.dig_data = dg;
            n = 0;
            while (bus.dig_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin checks++; errors++; $display("FAIL dig_ready_timeout got 0 expected 1"); end
            @(negedge clk);
            bus.dig_valid = 1'b0; bus.dig_data = rand_dig();
            chk("m_latency", 64'(bus.m_valid), 64'd1);
          end
        end else begin
          stalled = 1; held = bus.blk_data;
        end
      end else begin
        stalled = 0; wait_n = 0;
        bus.blk_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // output monitor: pops the expected beat on every m_valid&&m_ready
  initial begin : monitor
    bit st;
    logic [63:0] hd;
    logic [64:0] e;
    bus.m_ready = 1'b0; st = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin st = 0; bus.m_ready = 1'b0; continue; end
      bus.m_ready = hold_m ? 1'b0 : toggle_m ? ~bus.m_ready : ($urandom_range(0, 2) != 0);
      if (bus.m_valid === 1'b1) begin
        if (st) chk("m_hold", bus.m_data, hd);
        if (bus.m_ready) begin
          st = 0;
          if (exp_beat.size() == 0) begin
            checks++; errors++; $display("FAIL beat_unexpected got %h expected none", bus.m_data);
          end else begin
            e = exp_beat.pop_front();
            chk("m_data", bus.m_data, e[63:0]);
            chk("m_last", 64'(bus.m_last), 64'(e[64]));
          end
        end else begin
          st = 1; hd = bus.m_data;
        end
      end else st = 0;
    end
  end

  initial begin : main
    logic [DW*64-1:0] d;
    int n;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_keep = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    msg.delete(); send_msg(1, rand_dig(), 2); wait_drain("empty");

    msg = '{8'h61, 8'h62, 8'h63};
    d = rand_dig(); d[63:0] = 64'hD8E8_8E55_1A5E_A13A;
    send_msg(1, d, 0); wait_drain("abc");

    make_msg(135); send_msg(1, rand_dig(), 0); wait_drain("135");
    make_msg(136); send_msg(1, rand_dig(), 1); wait_drain("136_full");
    make_msg(136); send_msg(1, rand_dig(), 2); wait_drain("136_empty_tail");

    stall5 = 1; toggle_m = 1; blk_count = 0;
    make_msg(300); send_msg(1, rand_dig(), 0); wait_drain("300");
    chk("blk_count_300", 64'(blk_count), 64'd3);
    stall5 = 0; toggle_m = 0;

    repeat (12) begin
      make_msg($urandom_range(0, 420)); send_msg(1, rand_dig(), 0); wait_drain("random");
    end

    // reset while a block is stalled in SEND
    hold_blk = 1;
    make_msg(20); send_msg(0, '0, 0);
    chk("busy_send", 64'(bus.busy), 64'd1);
    rst_n = 1'b0; #1;
    check_reset("mid_send");
    @(negedge clk); rst_n = 1'b1; hold_blk = 0; @(negedge clk);

    // reset while digest beats are stalled in EMIT
    hold_m = 1;
    make_msg(50); send_msg(1, rand_dig(), 0);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin checks++; errors++; $display("FAIL emit_timeout got 0 expected 1"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    check_reset("mid_emit");
    exp_beat.delete(); dig_src.delete(); exp_blk.delete();
    @(negedge clk); rst_n = 1'b1; hold_m = 0; @(negedge clk);

    make_msg(77); send_msg(1, rand_dig(), 0); wait_drain("after_reset");
    make_msg(0);  send_msg(1, rand_dig(), 2); wait_drain("empty_after_reset");

    chk("queues_empty", 64'(exp_blk.size() + exp_beat.size() + dig_src.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
